// File: rtl/neuron_mac_if.sv
// Handshake and data bundle between a neuron feeder and the neuron_mac datapath.
// The feeder drives pairs and bias; the MAC returns readiness, status and the saturated sum.
interface neuron_mac_if;
    logic               start;
    logic               in_valid;
    logic signed [15:0] x_in;
    logic signed [15:0] w_in;
    logic signed [21:0] bias;
    logic               in_ready;
    logic               busy;
    logic        [21:0] dout;
    logic               dout_valid;
    logic               sat;

    modport master (
        output start, in_valid, x_in, w_in, bias,
        input  in_ready, busy, dout, dout_valid, sat
    );

    modport slave (
        input  start, in_valid, x_in, w_in, bias,
        output in_ready, busy, dout, dout_valid, sat
    );
endinterface

// File: rtl/neuron_mac.sv
// Single-neuron multiply-accumulate: sums N_IN Q1.14 products, adds a Q7.14 bias
// and emits the result saturated to 22 bits for the downstream sigmoid stage.
module neuron_mac #(
    parameter int N_IN = 784
) (
    input  logic         clk,
    input  logic         rst,
    neuron_mac_if.slave  bus
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACC  = 2'd1;
    localparam logic [1:0] BIAS = 2'd2;
    localparam logic [1:0] OUT  = 2'd3;

    localparam logic [9:0]         LAST    = 10'(N_IN - 1);
    localparam logic signed [31:0] SAT_MAX = 32'sd2097151;
    localparam logic signed [31:0] SAT_MIN = -32'sd2097152;

    logic [1:0]         state;
    logic signed [31:0] acc;
    logic [9:0]         cnt;
    logic [21:0]        dout_q;
    logic               sat_q;
    logic               dout_valid_q;

    logic               accept;
    logic signed [31:0] product;
    logic signed [31:0] term;
    logic signed [31:0] bias_ext;
    logic [21:0]        sat_val;
    logic               sat_flag;

    assign accept   = bus.in_valid && (state == ACC);
    // Full-width signed product; the arithmetic shift floors back to Q.14 scale.
    assign product  = $signed(bus.x_in) * $signed(bus.w_in);
    assign term     = product >>> 14;
    assign bias_ext = {{10{bus.bias[21]}}, bus.bias};

    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        sat_val  = acc[21:0];
        sat_flag = 1'b0;
        if (acc > SAT_MAX) begin
            sat_val  = 22'h1FFFFF;
            sat_flag = 1'b1;
        end else if (acc < SAT_MIN) begin
            sat_val  = 22'h200000;
            sat_flag = 1'b1;
        end
    end

    // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            acc          <= '0;
            cnt          <= '0;
            dout_q       <= '0;
            sat_q        <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            dout_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc   <= '0;
                        cnt   <= '0;
                        state <= ACC;
                    end
                end
                ACC: begin
                    if (accept) begin
                        acc <= acc + term;
                        cnt <= cnt + 10'd1;
                        if (cnt == LAST) begin
                            state <= BIAS;
                        end
                    end
                end
                BIAS: begin
                    acc   <= acc + bias_ext;
                    state <= OUT;
                end
                OUT: begin
                    dout_q       <= sat_val;
                    sat_q        <= sat_flag;
                    dout_valid_q <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status decodes straight from state so reset clears them without waiting for an edge.
    assign bus.in_ready   = (state == ACC);
    assign bus.busy       = (state != IDLE);
    assign bus.dout       = dout_q;
    assign bus.sat        = sat_q;
    assign bus.dout_valid = dout_valid_q;

endmodule

// File: tb/tb_neuron_mac.sv
// Directed bench for neuron_mac with N_IN=4: hand-computed sums, saturation limits,
// stalls, ignored start pulses, back-to-back runs and asynchronous reset behaviour.
module tb_neuron_mac;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   n_dv     = 0;
    int   exp_dv   = 0;
    logic [21:0] last_dout = '0;
    logic [15:0] xv [4];
    logic [15:0] wv [4];

    neuron_mac_if m ();

    neuron_mac #(.N_IN(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (m)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (m.dout_valid) n_dv <= n_dv + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", name, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check($sformatf("%s.dout", tag),       32'(m.dout),       32'h0);
        check($sformatf("%s.sat", tag),        32'(m.sat),        32'h0);
        check($sformatf("%s.dout_valid", tag), 32'(m.dout_valid), 32'h0);
        check($sformatf("%s.in_ready", tag),   32'(m.in_ready),   32'h0);
        check($sformatf("%s.busy", tag),       32'(m.busy),       32'h0);
    endtask

    // One evaluation from the current (IDLE) cycle; uses xv/wv as the four pairs.
    task automatic run_eval(input string tag, input logic [21:0] b, input bit gaps,
                            input int abort_after, input logic [21:0] exp_dout, input logic exp_sat);
        m.bias  = b;
        m.start = 1'b1;
        step();
        m.start = 1'b0;
        check($sformatf("%s.busy_acc", tag), 32'(m.busy), 32'h1);
        check($sformatf("%s.dv_count", tag), 32'(n_dv), 32'(exp_dv));
        check($sformatf("%s.hold", tag), 32'(m.dout), 32'(last_dout));
        for (int i = 0; i < 4; i++) begin
            for (int g = 0; g < (gaps ? i : 0); g++) begin
                m.in_valid = 1'b0;
                m.x_in     = 16'h7FFF;
                m.w_in     = 16'h7FFF;
                m.start    = (g == 0);
                step();
                m.start    = 1'b0;
            end
            m.x_in     = xv[i];
            m.w_in     = wv[i];
            m.in_valid = 1'b1;
            check($sformatf("%s.in_ready%0d", tag, i), 32'(m.in_ready), 32'h1);
            step();
            m.in_valid = 1'b0;
            m.x_in     = 16'h7FFF;
            m.w_in     = 16'h7FFF;
            if (abort_after == i + 1) begin
                #2 rst = 1'b1;
                #1;
                check_reset_outputs($sformatf("%s.abort", tag));
                last_dout = '0;
                step();
                rst = 1'b0;
                return;
            end
        end
        check($sformatf("%s.bias_ready", tag), 32'(m.in_ready), 32'h0);
        check($sformatf("%s.bias_dv", tag), 32'(m.dout_valid), 32'h0);
        step();
        check($sformatf("%s.out_dv", tag), 32'(m.dout_valid), 32'h0);
        check($sformatf("%s.out_busy", tag), 32'(m.busy), 32'h1);
        step();
        check($sformatf("%s.dv", tag), 32'(m.dout_valid), 32'h1);
        check($sformatf("%s.dout", tag), 32'(m.dout), 32'(exp_dout));
        check($sformatf("%s.sat", tag), 32'(m.sat), 32'(exp_sat));
        check($sformatf("%s.idle", tag), 32'(m.busy), 32'h0);
        last_dout = exp_dout;
        exp_dv++;
    endtask

    initial begin
        rst        = 1'b1;
        m.start    = 1'b0;
        m.in_valid = 1'b0;
        m.x_in     = '0;
        m.w_in     = '0;
        m.bias     = '0;
        #1;
        check_reset_outputs("por");
        step();
        step();
        rst = 1'b0;

        // Pairs offered while idle must be ignored.
        m.in_valid = 1'b1;
        m.x_in     = 16'h7FFF;
        m.w_in     = 16'h7FFF;
        step();
        step();
        check("idle_ready", 32'(m.in_ready), 32'h0);
        check("idle_busy", 32'(m.busy), 32'h0);
        m.in_valid = 1'b0;

        // 1 + 0.5 - 0.5 + 0 + bias 1.0 = 2.0
        xv = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        wv = '{16'h4000, 16'h2000, 16'hE000, 16'h0000};
        run_eval("basic", 22'h004000, 1'b0, 0, 22'h008000, 1'b0);

        // Chained immediately from the dout_valid cycle: positive overflow.
        xv = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        wv = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        run_eval("sat_pos", 22'h1FFFFF, 1'b0, 0, 22'h1FFFFF, 1'b1);

        // Negative overflow, also chained.
        xv = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
        wv = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        run_eval("sat_neg", 22'h200000, 1'b0, 0, 22'h200000, 1'b1);

        // Floor on negative product: -1 + 0 + 3 + 3 - 16 = -11
        step();
        xv = '{16'h0001, 16'h0001, 16'h0003, 16'h7FFF};
        wv = '{16'hFFFF, 16'h0001, 16'h4000, 16'h0002};
        run_eval("floor", 22'h3FFFF0, 1'b0, 0, 22'h3FFFF5, 1'b0);

        // Exact limits are representable and not flagged.
        step();
        xv = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        wv = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
        run_eval("edge_max", 22'h1FFFFF, 1'b0, 0, 22'h1FFFFF, 1'b0);
        run_eval("edge_min", 22'h200000, 1'b0, 0, 22'h200000, 1'b0);

        // Stalls of 0..3 cycles with start pulses inside ACC.
        step();
        xv = '{16'h4000, 16'h4000, 16'h4000, 16'h4000};
        wv = '{16'h4000, 16'h2000, 16'hE000, 16'h0000};
        run_eval("gaps", 22'h004000, 1'b1, 0, 22'h008000, 1'b0);
        step();
        check("gaps.one_pulse", 32'(n_dv), 32'(exp_dv));
        check("gaps.dv_low", 32'(m.dout_valid), 32'h0);

        // Reset after two accepts, then a clean rerun.
        run_eval("abort", 22'h004000, 1'b0, 2, 22'h008000, 1'b0);
        step();
        run_eval("rerun", 22'h004000, 1'b0, 0, 22'h008000, 1'b0);

        // Leave sat set, then assert reset between edges.
        xv = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        wv = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        run_eval("pre_rst", 22'h1FFFFF, 1'b0, 0, 22'h1FFFFF, 1'b1);
        step();
        check("final.dv_count", 32'(n_dv), 32'(exp_dv));
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("async");
        step();
        rst = 1'b0;
        step();
        check("post_rst.dv_count", 32'(n_dv), 32'(exp_dv));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
